// File: rtl/mole_pkg.sv
`default_nettype none
// ============================================================================
// mole_pkg : shared types, constants and helpers for the whack-a-mole controller
// Revision : 1.0
// ============================================================================
package mole_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SPAWN     = 3'd1,
        UP        = 3'd2,
        HIT_SHOW  = 3'd3,
        MISS_SHOW = 3'd4,
        GAME_OVER = 3'd5
    } state_t;

    localparam int         POS_W   = 4;
    localparam logic [3:0] BCD_MAX = 4'd9;

    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] ones;
    } bcd2_t;

    // Two-digit BCD increment that holds at 99.
    function automatic bcd2_t bcd_inc_sat(input bcd2_t s);
        bcd2_t r;
        r = s;
        if (s.ones == BCD_MAX) begin
            if (s.tens != BCD_MAX) begin
                r.ones = 4'd0;
                r.tens = s.tens + 4'd1;
            end
        end else begin
            r.ones = s.ones + 4'd1;
        end
        return r;
    endfunction

    // A respawn never lands on the hole the mole just left.
    function automatic logic [POS_W-1:0] next_pos(input logic [POS_W-1:0] rnd,
                                                  input logic [POS_W-1:0] old);
        return (rnd == old) ? rnd + POS_W'(1) : rnd;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mole_game_ctrl_if.sv
`default_nettype none
// ============================================================================
// mole_game_ctrl_if : game inputs (switch, tick, keypad, random) and display outputs
// Revision : 1.0
// ============================================================================
interface mole_game_ctrl_if #(
    parameter int MISS_W = 8
);
    logic              inGame;
    logic              tick_lvl;
    logic              key_down;
    logic [3:0]        key_code;
    logic [3:0]        rnd_pos;
    logic [3:0]        mole_pos;
    logic              mole_vis;
    logic              hit_pulse;
    logic              hit_flash;
    logic [3:0]        score_ones;
    logic [3:0]        score_tens;
    logic [MISS_W-1:0] miss_cnt;

    modport master (
        output inGame, tick_lvl, key_down, key_code, rnd_pos,
        input  mole_pos, mole_vis, hit_pulse, hit_flash,
        input  score_ones, score_tens, miss_cnt
    );

    modport slave (
        input  inGame, tick_lvl, key_down, key_code, rnd_pos,
        output mole_pos, mole_vis, hit_pulse, hit_flash,
        output score_ones, score_tens, miss_cnt
    );
endinterface
`default_nettype wire

// File: rtl/mole_game_ctrl_sync_edge.sv
`default_nettype none
// ============================================================================
// sync_edge : two-flop synchroniser followed by a registered rising-edge pulse
// Revision : 1.0
// ============================================================================
module sync_edge (
    input  wire  clk,
    input  wire  rst,
    input  wire  d,
    output logic pulse
);
    logic meta;
    logic sync;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta   <= 1'b0;
            sync   <= 1'b0;
            sync_q <= 1'b0;
            pulse  <= 1'b0;
        end else begin
            meta   <= d;
            sync   <= meta;
            sync_q <= sync;
            pulse  <= sync & ~sync_q;
        end
    end
endmodule
`default_nettype wire

// File: rtl/mole_game_ctrl.sv
`default_nettype none
// ============================================================================
// mole_game_ctrl : whack-a-mole round FSM, visibility timer, BCD score, misses
// Revision : 1.0
// ============================================================================
module mole_game_ctrl
    import mole_pkg::*;
#(
    parameter int UP_TICKS   = 4,
    parameter int SHOW_TICKS = 2,
    parameter int MISS_W     = 8
) (
    input  wire             clk,
    input  wire             rst,
    mole_game_ctrl_if.slave bus
);
    localparam int TCNT_MAX = (UP_TICKS > SHOW_TICKS) ? UP_TICKS : SHOW_TICKS;
    localparam int TCNT_W   = $clog2(TCNT_MAX + 1);
    localparam logic [TCNT_W-1:0] UP_LAST   = TCNT_W'(UP_TICKS - 1);
    localparam logic [TCNT_W-1:0] SHOW_LAST = TCNT_W'(SHOW_TICKS - 1);

    logic key_ev;
    logic tick_ev;

    sync_edge u_key_sync (
        .clk   (clk),
        .rst   (rst),
        .d     (bus.key_down),
        .pulse (key_ev)
    );

    sync_edge u_tick_sync (
        .clk   (clk),
        .rst   (rst),
        .d     (bus.tick_lvl),
        .pulse (tick_ev)
    );

    state_t            state;
    logic [TCNT_W-1:0] tcnt;
    logic [POS_W-1:0]  mole_pos;
    logic              mole_vis;
    logic              hit_pulse;
    logic              hit_flash;
    bcd2_t             score;
    logic [MISS_W-1:0] miss_cnt;

    logic              key_hit;
    logic              key_wrong;
    logic              escape;
    logic [1:0]        miss_add;
    logic [MISS_W:0]   miss_sum;
    logic [MISS_W-1:0] miss_next;

    // key_code is stable on the key_ev cycle, so it is compared directly here.
    always_comb begin
        key_hit   = key_ev && (bus.key_code == mole_pos);
        key_wrong = key_ev && !key_hit;
        escape    = tick_ev && (tcnt == UP_LAST);
        miss_add  = {1'b0, key_wrong} + {1'b0, escape};
        miss_sum  = {1'b0, miss_cnt} + (MISS_W + 1)'(miss_add);
        miss_next = miss_sum[MISS_W] ? {MISS_W{1'b1}} : miss_sum[MISS_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            tcnt      <= '0;
            mole_pos  <= '0;
            mole_vis  <= 1'b0;
            hit_pulse <= 1'b0;
            hit_flash <= 1'b0;
            score     <= '0;
            miss_cnt  <= '0;
        end else begin
            hit_pulse <= 1'b0;
            case (state)
                IDLE, GAME_OVER: begin
                    mole_vis  <= 1'b0;
                    hit_flash <= 1'b0;
                    if (bus.inGame) begin
                        score    <= '0;
                        miss_cnt <= '0;
                        state    <= SPAWN;
                    end
                end

                SPAWN: begin
                    if (!bus.inGame) begin
                        state <= GAME_OVER;
                    end else begin
                        mole_pos <= next_pos(bus.rnd_pos, mole_pos);
                        tcnt     <= '0;
                        mole_vis <= 1'b1;
                        state    <= UP;
                    end
                end

                UP: begin
                    if (!bus.inGame) begin
                        mole_vis <= 1'b0;
                        state    <= GAME_OVER;
                    end else if (key_hit) begin
                        // A hit outranks an escape arriving on the same cycle.
                        hit_pulse <= 1'b1;
                        score     <= bcd_inc_sat(score);
                        mole_vis  <= 1'b0;
                        hit_flash <= 1'b1;
                        tcnt      <= '0;
                        state     <= HIT_SHOW;
                    end else begin
                        miss_cnt <= miss_next;
                        if (escape) begin
                            mole_vis <= 1'b0;
                            tcnt     <= '0;
                            state    <= MISS_SHOW;
                        end else if (tick_ev) begin
                            tcnt <= tcnt + TCNT_W'(1);
                        end
                    end
                end

                HIT_SHOW, MISS_SHOW: begin
                    if (!bus.inGame) begin
                        hit_flash <= 1'b0;
                        state     <= GAME_OVER;
                    end else if (tick_ev) begin
                        if (tcnt == SHOW_LAST) begin
                            hit_flash <= 1'b0;
                            state     <= SPAWN;
                        end else begin
                            tcnt <= tcnt + TCNT_W'(1);
                        end
                    end
                end

                default: begin
                    mole_vis  <= 1'b0;
                    hit_flash <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    assign bus.mole_pos   = mole_pos;
    assign bus.mole_vis   = mole_vis;
    assign bus.hit_pulse  = hit_pulse;
    assign bus.hit_flash  = hit_flash;
    assign bus.score_ones = score.ones;
    assign bus.score_tens = score.tens;
    assign bus.miss_cnt   = miss_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mole_game_ctrl.sv
`default_nettype none
// ============================================================================
// tb_mole_game_ctrl : directed self-checking bench for mole_game_ctrl
// Revision : 1.0
// ============================================================================
module tb_mole_game_ctrl;
    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   hit_count;

    mole_game_ctrl_if #(.MISS_W(8)) bus ();

    mole_game_ctrl #(
        .UP_TICKS   (4),
        .SHOW_TICKS (2),
        .MISS_W     (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst && bus.hit_pulse) hit_count++;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One tick_lvl period: long enough for the synchroniser to see both levels.
    task automatic do_tick();
        bus.tick_lvl = 1'b1;
        wait_cyc(4);
        bus.tick_lvl = 1'b0;
        wait_cyc(4);
    endtask

    task automatic press(input logic [3:0] code);
        bus.key_code = code;
        bus.key_down = 1'b1;
        wait_cyc(6);
        bus.key_down = 1'b0;
        wait_cyc(4);
    endtask

    logic [3:0] pos;
    logic [3:0] rnd;
    int         first_hi;
    int         n_hi;
    logic [3:0] ones_at_hit;

    initial begin
        checks = 0; failures = 0; hit_count = 0;
        rst = 1'b1;
        bus.inGame = 1'b0; bus.tick_lvl = 1'b0; bus.key_down = 1'b0;
        bus.key_code = 4'd0; bus.rnd_pos = 4'd0;
        wait_cyc(3);

        check_val("rst_mole_vis",  32'(bus.mole_vis),  0);
        check_val("rst_mole_pos",  32'(bus.mole_pos),  0);
        check_val("rst_score",     32'({bus.score_tens, bus.score_ones}), 0);
        check_val("rst_miss",      32'(bus.miss_cnt),  0);
        check_val("rst_hit_flash", 32'(bus.hit_flash), 0);

        // Start a game: first mole at hole 5.
        bus.rnd_pos = 4'd5;
        bus.inGame  = 1'b1;
        rst = 1'b0;
        wait_cyc(4);
        check_val("spawn_vis", 32'(bus.mole_vis), 1);
        check_val("spawn_pos", 32'(bus.mole_pos), 5);

        // Hit latency: pulse expected in cycle N+3 and only once.
        bus.key_code = 4'd5;
        bus.key_down = 1'b1;
        first_hi = -1; n_hi = 0; ones_at_hit = 4'hF;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.hit_pulse) begin
                n_hi++;
                if (first_hi < 0) begin
                    first_hi = i;
                    ones_at_hit = bus.score_ones;
                end
            end
        end
        bus.key_down = 1'b0;
        wait_cyc(4);
        check_val("hit_latency",   32'(first_hi), 3);
        check_val("hit_once",      32'(n_hi), 1);
        check_val("hit_score_now", 32'(ones_at_hit), 1);
        check_val("hit_score",     32'({bus.score_tens, bus.score_ones}), 32'h01);
        check_val("hit_flash_on",  32'(bus.hit_flash), 1);
        check_val("hit_vis_off",   32'(bus.mole_vis), 0);
        do_tick();
        check_val("hit_flash_t1",  32'(bus.hit_flash), 1);
        do_tick();
        check_val("hit_flash_t2",  32'(bus.hit_flash), 0);
        check_val("respawn_vis",   32'(bus.mole_vis), 1);
        check_val("respawn_pos",   32'(bus.mole_pos), 6);

        // Wrong key, then escape after four ticks.
        press(4'd3);
        check_val("wrong_miss",  32'(bus.miss_cnt), 1);
        check_val("wrong_stay",  32'(bus.mole_vis), 1);
        do_tick(); do_tick(); do_tick();
        check_val("pre_escape_vis",  32'(bus.mole_vis), 1);
        check_val("pre_escape_miss", 32'(bus.miss_cnt), 1);
        do_tick();
        check_val("escape_miss",  32'(bus.miss_cnt), 2);
        check_val("escape_vis",   32'(bus.mole_vis), 0);
        check_val("escape_flash", 32'(bus.hit_flash), 0);
        bus.rnd_pos = 4'd15;
        do_tick();
        check_val("missshow_vis", 32'(bus.mole_vis), 0);
        do_tick();
        check_val("spawn15_pos", 32'(bus.mole_pos), 15);
        check_val("spawn15_vis", 32'(bus.mole_vis), 1);

        // Held wrong key across three ticks counts as one event.
        bus.key_code = 4'd3;
        bus.key_down = 1'b1;
        do_tick(); do_tick(); do_tick();
        bus.key_down = 1'b0;
        wait_cyc(4);
        check_val("held_miss", 32'(bus.miss_cnt), 3);
        check_val("held_vis",  32'(bus.mole_vis), 1);
        do_tick();
        check_val("held_escape", 32'(bus.miss_cnt), 4);
        do_tick(); do_tick();
        check_val("wrap_pos", 32'(bus.mole_pos), 0);
        check_val("wrap_vis", 32'(bus.mole_vis), 1);

        // inGame drops on the very cycle a correct key_ev reaches the FSM.
        bus.key_code = 4'd0;
        bus.key_down = 1'b1;
        wait_cyc(3);
        bus.inGame = 1'b0;
        wait_cyc(1);
        check_val("over_no_pulse", 32'(bus.hit_pulse), 0);
        bus.key_down = 1'b0;
        wait_cyc(6);
        check_val("over_score", 32'({bus.score_tens, bus.score_ones}), 32'h01);
        check_val("over_miss",  32'(bus.miss_cnt), 4);
        check_val("over_vis",   32'(bus.mole_vis), 0);
        check_val("over_flash", 32'(bus.hit_flash), 0);

        // Restart clears score and misses.
        bus.rnd_pos = 4'd7;
        bus.inGame  = 1'b1;
        wait_cyc(4);
        check_val("restart_score", 32'({bus.score_tens, bus.score_ones}), 0);
        check_val("restart_miss",  32'(bus.miss_cnt), 0);
        check_val("restart_pos",   32'(bus.mole_pos), 7);
        check_val("restart_vis",   32'(bus.mole_vis), 1);

        // 100 consecutive hits: carry at 10, saturation at 99.
        pos = 4'd7;
        for (int i = 0; i < 100; i++) begin
            press(pos);
            rnd = 4'((i * 7 + 3) % 16);
            bus.rnd_pos = rnd;
            do_tick(); do_tick();
            pos = (rnd == pos) ? rnd + 4'd1 : rnd;
            if (i == 9) begin
                check_val("carry_score", 32'({bus.score_tens, bus.score_ones}), 32'h10);
                check_val("carry_pos",   32'(bus.mole_pos), 32'(pos));
            end
        end
        check_val("sat_tens", 32'(bus.score_tens), 9);
        check_val("sat_ones", 32'(bus.score_ones), 9);
        check_val("sat_miss", 32'(bus.miss_cnt), 0);
        check_val("hit_total", 32'(hit_count), 101);

        // Reset mid-UP with a correct key already in the pipeline.
        bus.key_code = pos;
        bus.key_down = 1'b1;
        wait_cyc(2);
        rst = 1'b1;
        wait_cyc(1);
        check_val("midrst_vis",   32'(bus.mole_vis), 0);
        check_val("midrst_pos",   32'(bus.mole_pos), 0);
        check_val("midrst_score", 32'({bus.score_tens, bus.score_ones}), 0);
        check_val("midrst_pulse", 32'(bus.hit_pulse), 0);
        check_val("midrst_flash", 32'(bus.hit_flash), 0);
        bus.key_down = 1'b0;
        wait_cyc(2);
        rst = 1'b0;
        wait_cyc(10);
        check_val("post_rst_hits",  32'(hit_count), 101);
        check_val("post_rst_score", 32'({bus.score_tens, bus.score_ones}), 0);
        check_val("post_rst_vis",   32'(bus.mole_vis), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
